// File: rtl/ahb_apb_bridge_param.sv
// ahb_apb_bridge_param: AHB-Lite to multi-slave APB bridge with posted-write buffer and error mapping
module ahb_apb_bridge_param #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int NUM_SLV = 3,
   parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int SLV_SPAN_LOG2 = 24,
   parameter int WBUF_DEPTH = 4
) (
   input  logic               Hclk,
   input  logic               Hreset,
   input  logic               Hwrite,
   input  logic               Hreadyin,
   input  logic [1:0]         Htrans,
   input  logic [AW-1:0]      Haddr,
   input  logic [DW-1:0]      Hwdata,
   output logic [DW-1:0]      Hrdata,
   output logic               Hreadyout,
   output logic [1:0]         Hresp,
   input  logic [DW-1:0]      Prdata,
   input  logic               Pready,
   input  logic               Pslverr,
   output logic [AW-1:0]      Paddr,
   output logic [DW-1:0]      Pwdata,
   output logic               Pwrite,
   output logic               Penable,
   output logic [NUM_SLV-1:0] Pselx,
   output logic               Wr_err
);
   localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;
   state_t st;

   logic [AW-1:0] off, idx_full, ph_addr, rd_addr;
   logic [IW-1:0] idx_now, ph_idx, rd_idx;
   logic          mapped_now, ph_valid, ph_write, ph_mapped, um2;
   logic          rd_issued, rd_done, hready, accept, push, pop, done, full;
   logic          ph_rd_pend, rd_req, free, wr_more, nxt_wr, nxt_rd;
   logic [PW-1:0] wp, rp, hd;
   logic [CW-1:0] cnt;
   logic [AW-1:0] fa [WBUF_DEPTH];
   logic [DW-1:0] fd [WBUF_DEPTH];
   logic [IW-1:0] fi [WBUF_DEPTH];

   function automatic logic [NUM_SLV-1:0] sel(input logic [IW-1:0] i);
      return NUM_SLV'(1) << i;
   endfunction

   assign off        = Haddr - BASE_ADDR;
   assign idx_full   = off >> SLV_SPAN_LOG2;
   assign idx_now    = idx_full[IW-1:0];
   assign mapped_now = (Haddr >= BASE_ADDR) && (idx_full < AW'(NUM_SLV));

   assign full      = cnt == CW'(WBUF_DEPTH);
   assign hready    = !ph_valid ? 1'b1 : !ph_mapped ? um2 : ph_write ? !full : (rd_done || st == ERR2);
   assign Hreadyout = hready;
   assign Hresp     = {1'b0, (ph_valid && !ph_mapped) || st == ERR1 || st == ERR2};

   assign accept     = hready && Hreadyin && Htrans[1];
   assign push       = ph_valid && ph_write && ph_mapped && !full;
   assign done       = st == ACCESS && Pready;
   assign pop        = done && Pwrite;
   assign ph_rd_pend = ph_valid && !ph_write && ph_mapped && !rd_issued && !rd_done;
   assign rd_req     = ph_rd_pend || (accept && !Hwrite && mapped_now);
   assign rd_addr    = ph_rd_pend ? ph_addr : Haddr;
   assign rd_idx     = ph_rd_pend ? ph_idx : idx_now;
   // the entry being popped is excluded when chaining writes back-to-back out of ACCESS
   assign free       = st == IDLE || pop;
   assign wr_more    = st == ACCESS ? cnt > CW'(1) : cnt != '0;
   assign hd         = st == ACCESS ? rp + PW'(1) : rp;
   assign nxt_wr     = free && wr_more;
   // a read waits while a write is still being pushed so it stays ordered behind it
   assign nxt_rd     = free && !wr_more && rd_req && !push;

   // AHB address-phase capture and unmapped two-cycle ERROR sequencing
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         ph_valid  <= 1'b0;
         ph_write  <= 1'b0;
         ph_mapped <= 1'b0;
         ph_addr   <= '0;
         ph_idx    <= '0;
         um2       <= 1'b0;
      end else begin
         um2 <= ph_valid && !ph_mapped && !um2;
         if (hready) begin
            ph_valid  <= Hreadyin && Htrans[1];
            ph_write  <= Hwrite;
            ph_mapped <= mapped_now;
            ph_addr   <= Haddr;
            ph_idx    <= idx_now;
         end
      end
   end

   // posted-write FIFO pointers and occupancy
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // posted-write FIFO storage
   always_ff @(posedge Hclk) begin
      if (push) begin
         fa[wp] <= ph_addr;
         fd[wp] <= Hwdata;
         fi[wp] <= ph_idx;
      end
   end

   // APB state machine with registered APB outputs, read data and write-error pulse
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         st        <= IDLE;
         Paddr     <= '0;
         Pwdata    <= '0;
         Pwrite    <= 1'b0;
         Penable   <= 1'b0;
         Pselx     <= '0;
         Wr_err    <= 1'b0;
         Hrdata    <= '0;
         rd_issued <= 1'b0;
         rd_done   <= 1'b0;
      end else begin
         Wr_err <= pop && Pslverr;
         if (hready) begin
            rd_issued <= 1'b0;
            rd_done   <= 1'b0;
         end
         if (nxt_wr) begin
            st      <= SETUP;
            Paddr   <= fa[hd];
            Pwdata  <= fd[hd];
            Pselx   <= sel(fi[hd]);
            Pwrite  <= 1'b1;
            Penable <= 1'b0;
         end else if (nxt_rd) begin
            st        <= SETUP;
            Paddr     <= rd_addr;
            Pselx     <= sel(rd_idx);
            Pwrite    <= 1'b0;
            Penable   <= 1'b0;
            rd_issued <= 1'b1;
         end else if (st == SETUP) begin
            st      <= ACCESS;
            Penable <= 1'b1;
         end else if (done) begin
            Penable <= 1'b0;
            Pselx   <= '0;
            st      <= (!Pwrite && Pslverr) ? ERR1 : IDLE;
            if (!Pwrite && !Pslverr) begin
               Hrdata  <= Prdata;
               rd_done <= 1'b1;
            end
         end else if (st == ERR1) begin
            st <= ERR2;
         end else if (st == ERR2) begin
            st <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// tb_ahb_apb_bridge_param: directed self-checking bench for the AHB to APB bridge
module tb_ahb_apb_bridge_param;
   logic        clk = 1'b0, rst = 1'b1;
   logic        hwrite = 1'b0, hreadyin, hreadyout, pready_r = 1'b1, pslverr_r = 1'b0;
   logic [1:0]  htrans = 2'b00, hresp;
   logic [31:0] haddr = '0, hwdata = '0, hrdata, prdata, paddr, pwdata;
   logic        pwrite, penable, wr_err;
   logic [2:0]  pselx;
   int          checks = 0, errors = 0, wcount = 0, selcnt = 0;
   int          wb, sc0, pulses, bad;
   logic [31:0] mem [16] = '{4: 32'hDEAD_BEEF, default: 32'h0};
   logic [31:0] log_addr [8], log_data [8];
   logic [2:0]  log_sel [8];
   logic [31:0] wa [5] = '{32'h8000_0020, 32'h8100_0024, 32'h8200_0028, 32'h8000_002C, 32'h8100_0030};
   logic [2:0]  ws [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

   ahb_apb_bridge_param dut (
      .Hclk(clk), .Hreset(rst), .Hwrite(hwrite), .Hreadyin(hreadyin), .Htrans(htrans),
      .Haddr(haddr), .Hwdata(hwdata), .Hrdata(hrdata), .Hreadyout(hreadyout), .Hresp(hresp),
      .Prdata(prdata), .Pready(pready_r), .Pslverr(pslverr_r), .Paddr(paddr), .Pwdata(pwdata),
      .Pwrite(pwrite), .Penable(penable), .Pselx(pselx), .Wr_err(wr_err)
   );

   always #5 clk = ~clk;
   assign hreadyin = hreadyout;
   assign prdata   = mem[paddr[5:2]];

   // APB slave: memory, write log and select-activity counter
   always @(posedge clk) begin
      if (pselx != 0) selcnt <= selcnt + 1;
      if (pselx != 0 && penable && pready_r && pwrite) begin
         mem[paddr[5:2]]       <= pwdata;
         log_addr[wcount[2:0]] <= paddr;
         log_data[wcount[2:0]] <= pwdata;
         log_sel[wcount[2:0]]  <= pselx;
         wcount                <= wcount + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst_hready", hreadyout, 1);
      chk("rst_hresp", hresp, 0);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_pselx", pselx, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_wr_err", wr_err, 0);
      rst = 1'b0;
      tick();
      // read slave 1 with nominal latency
      htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8100_0010;
      chk("t1_addr_ready", hreadyout, 1);
      tick();
      htrans = 2'b00;
      chk("t1_setup_sel", pselx, 3'b010);
      chk("t1_setup_pen", penable, 0);
      chk("t1_setup_paddr", paddr, 32'h8100_0010);
      chk("t1_wait1", hreadyout, 0);
      tick();
      chk("t1_access_pen", penable, 1);
      chk("t1_wait2", hreadyout, 0);
      tick();
      chk("t1_ready", hreadyout, 1);
      chk("t1_hrdata", hrdata, 32'hDEAD_BEEF);
      chk("t1_hresp", hresp, 0);
      chk("t1_idle_sel", pselx, 0);
      tick();
      // five back-to-back posted writes with Pready low
      pready_r = 1'b0; wb = wcount;
      htrans = 2'b10; hwrite = 1'b1; haddr = wa[0];
      tick();
      for (int i = 1; i < 5; i++) begin
         hwdata = 32'h1111_0000 + 32'(i - 1); haddr = wa[i];
         chk("t2_zero_wait", hreadyout, 1);
         tick();
      end
      hwdata = 32'h1111_0004; htrans = 2'b00;
      chk("t2_full_stall", hreadyout, 0);
      tick();
      chk("t2_still_full", hreadyout, 0);
      chk("t2_wait_state_pen", penable, 1);
      chk("t2_wait_state_sel", pselx, 3'b001);
      pready_r = 1'b1;
      tick();
      chk("t2_released", hreadyout, 1);
      tick();
      for (int k = 0; k < 50 && wcount < wb + 5; k++) tick();
      chk("t2_all_written", wcount, wb + 5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_log_addr", log_addr[(wb + i) % 8], wa[i]);
         chk("t2_log_data", log_data[(wb + i) % 8], 32'h1111_0000 + 32'(i));
         chk("t2_log_sel", log_sel[(wb + i) % 8], ws[i]);
      end
      tick();
      // write then read same address: the read must see the written data
      wb = wcount;
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0004;
      tick();
      hwdata = 32'hCAFE_0001; hwrite = 1'b0;
      chk("t3_wr_ack", hreadyout, 1);
      tick();
      htrans = 2'b00;
      chk("t3_rd_wait", hreadyout, 0);
      tick();
      chk("t3_wr_setup_dir", pwrite, 1);
      chk("t3_wr_setup_sel", pselx, 3'b001);
      tick();
      tick();
      chk("t3_wr_done", wcount, wb + 1);
      chk("t3_rd_setup_dir", pwrite, 0);
      chk("t3_rd_setup_sel", pselx, 3'b001);
      tick();
      tick();
      chk("t3_rd_ready", hreadyout, 1);
      chk("t3_rd_data", hrdata, 32'hCAFE_0001);
      tick();
      // unmapped read: two-cycle ERROR, no APB activity
      sc0 = selcnt;
      htrans = 2'b10; haddr = 32'h8400_0000;
      tick();
      htrans = 2'b00;
      chk("t4_err1_ready", hreadyout, 0);
      chk("t4_err1_resp", hresp, 2'b01);
      chk("t4_err1_sel", pselx, 0);
      tick();
      chk("t4_err2_ready", hreadyout, 1);
      chk("t4_err2_resp", hresp, 2'b01);
      tick();
      chk("t4_okay", hresp, 0);
      chk("t4_no_apb", selcnt, sc0);
      // read with three wait states then Pslverr
      pready_r = 1'b0;
      htrans = 2'b10; haddr = 32'h8200_0008;
      tick();
      htrans = 2'b00;
      chk("t5_setup_sel", pselx, 3'b100);
      tick();
      chk("t5_acc1", penable, 1);
      tick();
      tick();
      chk("t5_acc3_wait", hreadyout, 0);
      pready_r = 1'b1; pslverr_r = 1'b1;
      tick();
      pslverr_r = 1'b0;
      chk("t5_err1_ready", hreadyout, 0);
      chk("t5_err1_resp", hresp, 2'b01);
      chk("t5_err1_sel", pselx, 0);
      tick();
      chk("t5_err2_ready", hreadyout, 1);
      chk("t5_err2_resp", hresp, 2'b01);
      chk("t5_hrdata_kept", hrdata, 32'hCAFE_0001);
      tick();
      chk("t5_okay", hresp, 0);
      // posted write with Pslverr: single Wr_err pulse, no AHB error
      pslverr_r = 1'b1;
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0008;
      tick();
      hwdata = 32'h0000_0055; htrans = 2'b00;
      chk("t5_wr_ack", hreadyout, 1);
      pulses = 0; bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (hresp != 0) bad++;
         tick();
         if (wr_err) pulses++;
      end
      pslverr_r = 1'b0;
      chk("t5_wr_err_pulse", pulses, 1);
      chk("t5_wr_no_hresp", bad, 0);
      // reset during ACCESS of a three-entry write burst
      pready_r = 1'b0;
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0040;
      tick();
      hwdata = 32'h1; haddr = 32'h8000_0044;
      tick();
      hwdata = 32'h2; haddr = 32'h8000_0048;
      tick();
      hwdata = 32'h3; htrans = 2'b00;
      tick();
      chk("t6_in_access", penable, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_sel", pselx, 0);
      chk("t6_rst_pen", penable, 0);
      chk("t6_rst_ready", hreadyout, 1);
      sc0 = selcnt; wb = wcount;
      tick();
      tick();
      rst = 1'b0; pready_r = 1'b1;
      repeat (6) tick();
      chk("t6_no_residual_sel", selcnt, sc0);
      chk("t6_no_residual_wr", wcount, wb);
      chk("t6_ready", hreadyout, 1);
      htrans = 2'b10; hwrite = 1'b0; haddr = 32'h8000_0004;
      tick();
      htrans = 2'b00;
      chk("t6_empty_rd_dir", pwrite, 0);
      chk("t6_empty_rd_sel", pselx, 3'b001);
      tick();
      tick();
      chk("t6_rd_ready", hreadyout, 1);
      chk("t6_rd_data", hrdata, 32'hCAFE_0001);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
